// File: rtl/gearbox_tx_param_if.sv
// Handshake and status bundle between a stream source and gearbox_tx_param.
// The master drives DATA_IN/DATA_IN_VALID; the slave (the gearbox) drives everything else.
interface gearbox_tx_param_if #(
  parameter int IN_W  = 67,
  parameter int OUT_W = 20
);
  localparam int STORE_W = IN_W + OUT_W - 1;
  localparam int CNT_W   = $clog2(STORE_W + 1);

  logic [IN_W-1:0]  DATA_IN;
  logic             DATA_IN_VALID;
  logic             DATA_IN_READY;
  logic [OUT_W-1:0] DATA_OUT;
  logic             DATA_OUT_VALID;
  logic [CNT_W-1:0] FILL_LEVEL;
  logic             UNDERRUN;

  modport master (
    output DATA_IN, DATA_IN_VALID,
    input  DATA_IN_READY, DATA_OUT, DATA_OUT_VALID, FILL_LEVEL, UNDERRUN
  );

  modport slave (
    input  DATA_IN, DATA_IN_VALID,
    output DATA_IN_READY, DATA_OUT, DATA_OUT_VALID, FILL_LEVEL, UNDERRUN
  );
endinterface

// File: rtl/gearbox_tx_param.sv
// IN_W -> OUT_W MSB-first TX gearbox; one-cycle latency, registered output; DATA_IN_READY drops when a whole word will not fit.
// Optional GEARBOX_TX_BIT_REVERSE_EN emits each chunk LSB-first (first-transmitted bit at DATA_OUT[0]).
module gearbox_tx_param #(
  parameter int IN_W  = 67,
  parameter int OUT_W = 20
) (
  input  logic              USER_CLK,
  input  logic              SYSTEM_RESET,
  gearbox_tx_param_if.slave bus
);
  localparam int STORE_W = IN_W + OUT_W - 1;
  localparam int CNT_W   = $clog2(STORE_W + 1);
  localparam logic [CNT_W-1:0] C_OUT_W   = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] C_IN_W    = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] C_RDY_MAX = CNT_W'(STORE_W - IN_W);

  logic [CNT_W-1:0]   r_cnt;
  logic [STORE_W-1:0] r_store;
  logic [OUT_W-1:0]   r_dout;
  logic               r_dout_vld;
  logic               r_underrun;
  logic               r_emitted;

  logic               w_drain;
  logic               w_rdy;
  logic               w_accept;
  logic [CNT_W-1:0]   w_cnt_d;
  logic [STORE_W-1:0] w_kept;
  logic [STORE_W-1:0] w_word;
  logic [OUT_W-1:0]   w_chunk;

  assign w_drain  = (r_cnt >= C_OUT_W);
  assign w_cnt_d  = w_drain ? (r_cnt - C_OUT_W) : r_cnt;
  assign w_rdy    = (w_cnt_d <= C_RDY_MAX);
  assign w_accept = bus.DATA_IN_VALID && w_rdy;
  assign w_kept   = w_drain ? (r_store << OUT_W) : r_store;
  // Bits below the retained ones are always zero, so the new word is simply OR-ed in underneath.
  assign w_word   = {bus.DATA_IN, {(OUT_W-1){1'b0}}} >> w_cnt_d;

  always_comb begin
    w_chunk = '0;
`ifdef GEARBOX_TX_BIT_REVERSE_EN
    for (int i = 0; i < OUT_W; i++) begin
      w_chunk[i] = r_store[STORE_W-1-i];
    end
`else
    w_chunk = r_store[STORE_W-1 -: OUT_W];
`endif
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      r_cnt      <= '0;
      r_store    <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_underrun <= 1'b0;
      r_emitted  <= 1'b0;
    end else begin
      r_cnt      <= w_accept ? (w_cnt_d + C_IN_W) : w_cnt_d;
      r_store    <= w_accept ? (w_kept | w_word) : w_kept;
      r_dout     <= w_drain ? w_chunk : '0;
      r_dout_vld <= w_drain;
      // Underrun is a gap in the output stream once it has started.
      if (w_drain) begin
        r_emitted <= 1'b1;
      end else if (r_emitted) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign bus.DATA_IN_READY  = w_rdy;
  assign bus.DATA_OUT       = r_dout;
  assign bus.DATA_OUT_VALID = r_dout_vld;
  assign bus.FILL_LEVEL     = r_cnt;
  assign bus.UNDERRUN       = r_underrun;
endmodule

// File: tb/tb_gearbox_tx_param.sv
// Bench for gearbox_tx_param: default 67->20 instance (directed + random) and a 66->32 instance (random stream).
// A bit-queue model predicts every output each cycle; literal checks pin the model to known sequences.
module tb_gearbox_tx_param;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  gearbox_tx_param_if #(.IN_W(67), .OUT_W(20)) bus_a ();
  gearbox_tx_param_if #(.IN_W(66), .OUT_W(32)) bus_b ();

  gearbox_tx_param #(.IN_W(67), .OUT_W(20)) dut_a (
    .USER_CLK(clk), .SYSTEM_RESET(rst_a), .bus(bus_a)
  );
  gearbox_tx_param #(.IN_W(66), .OUT_W(32)) dut_b (
    .USER_CLK(clk), .SYSTEM_RESET(rst_b), .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_a = 1'b0;
  bit chk_b = 1'b0;
  bit b_done = 1'b0;

  // Model state: stored bits in transmission order, plus expected registered outputs.
  bit        mq [2][$];
  bit [31:0] e_dat [2];
  bit        e_vld [2];
  bit        e_und [2];
  bit        e_emit [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_rdy(input int k, input int iw, input int ow);
    int sz;
    int cnt_d;
    sz = mq[k].size();
    cnt_d = (sz >= ow) ? sz - ow : sz;
    return (cnt_d + iw <= iw + ow - 1);
  endfunction

  task automatic model_step(input int k, input int iw, input int ow, input logic rst,
                            input logic v, input logic [127:0] din);
    bit drain;
    bit rdy;
    bit b;
    if (rst) begin
      mq[k].delete();
      e_dat[k] = '0; e_vld[k] = 1'b0; e_und[k] = 1'b0; e_emit[k] = 1'b0;
      return;
    end
    rdy   = model_rdy(k, iw, ow);
    drain = (mq[k].size() >= ow);
    e_dat[k] = '0;
    e_vld[k] = drain;
    if (drain) begin
      for (int i = 0; i < ow; i++) begin
        b = mq[k].pop_front();
`ifdef GEARBOX_TX_BIT_REVERSE_EN
        e_dat[k][i] = b;
`else
        e_dat[k][ow-1-i] = b;
`endif
      end
    end
    if (!drain && e_emit[k]) e_und[k] = 1'b1;
    if (drain) e_emit[k] = 1'b1;
    if (v && rdy) begin
      for (int i = iw - 1; i >= 0; i--) mq[k].push_back(din[i]);
    end
  endtask

  task automatic check_dut(input int k, input int iw, input int ow, input logic [31:0] dat,
                           input logic vld, input logic [31:0] fill, input logic und, input logic rdy);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, "_data_out"}, dat, e_dat[k]);
    chk({p, "_data_out_valid"}, {31'b0, vld}, {31'b0, e_vld[k]});
    chk({p, "_fill_level"}, fill, mq[k].size());
    chk({p, "_underrun"}, {31'b0, und}, {31'b0, e_und[k]});
    chk({p, "_data_in_ready"}, {31'b0, rdy}, {31'b0, model_rdy(k, iw, ow)});
  endtask

  always @(posedge clk) begin
    model_step(0, 67, 20, rst_a, bus_a.DATA_IN_VALID, {61'b0, bus_a.DATA_IN});
    model_step(1, 66, 32, rst_b, bus_b.DATA_IN_VALID, {62'b0, bus_b.DATA_IN});
  end

  always @(negedge clk) begin
    if (chk_a)
      check_dut(0, 67, 20, {12'b0, bus_a.DATA_OUT}, bus_a.DATA_OUT_VALID,
                {25'b0, bus_a.FILL_LEVEL}, bus_a.UNDERRUN, bus_a.DATA_IN_READY);
    if (chk_b) begin
      check_dut(1, 66, 32, bus_b.DATA_OUT, bus_b.DATA_OUT_VALID,
                {25'b0, bus_b.FILL_LEVEL}, bus_b.UNDERRUN, bus_b.DATA_IN_READY);
      if (bus_b.FILL_LEVEL > 7'd97) chk("b_fill_max", {25'b0, bus_b.FILL_LEVEL}, 32'd97);
    end
  end

  function automatic logic [19:0] top_chunk(input logic [66:0] w);
    logic [19:0] c;
    c = w[66:47];
`ifdef GEARBOX_TX_BIT_REVERSE_EN
    for (int i = 0; i < 20; i++) c[i] = w[66-i];
`endif
    return c;
  endfunction

  function automatic logic [66:0] rand67();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[66:0];
  endfunction

  task automatic reset_a();
    rst_a = 1'b1;
    bus_a.DATA_IN_VALID = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
  endtask

  // Stream B: 66->32 with random valid gaps.
  initial begin : drive_b
    logic [95:0] r;
    bus_b.DATA_IN_VALID = 1'b0;
    bus_b.DATA_IN = '0;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    chk_b = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = {$urandom(), $urandom(), $urandom()};
      bus_b.DATA_IN = r[65:0];
      bus_b.DATA_IN_VALID = ($urandom_range(0, 3) != 0);
    end
    b_done = 1'b1;
  end

  initial begin : drive_a
    int fill_exp[4];
    int rdy_exp[3];
    int nv;
    logic [19:0] exp_first;
    logic [66:0] w;
    fill_exp = '{67, 47, 27, 74};
    rdy_exp  = '{0, 0, 1};
    bus_a.DATA_IN = '0;
    bus_a.DATA_IN_VALID = 1'b0;

    // Reset state and continuous-valid fill sequence.
    reset_a();
    chk_a = 1'b1;
    chk("rst_fill", {25'b0, bus_a.FILL_LEVEL}, 32'd0);
    chk("rst_valid", {31'b0, bus_a.DATA_OUT_VALID}, 32'd0);
    chk("rst_underrun", {31'b0, bus_a.UNDERRUN}, 32'd0);
    chk("rst_ready", {31'b0, bus_a.DATA_IN_READY}, 32'd1);
    chk("rst_data", {12'b0, bus_a.DATA_OUT}, 32'd0);
    bus_a.DATA_IN = rand67();
    bus_a.DATA_IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_a.DATA_IN = rand67();
      chk("seq_fill", {25'b0, bus_a.FILL_LEVEL}, fill_exp[i]);
      if (i < 3) chk("seq_ready", {31'b0, bus_a.DATA_IN_READY}, rdy_exp[i]);
    end
    repeat (40) begin
      @(negedge clk);
      bus_a.DATA_IN = rand67();
    end
    chk("seq_no_underrun", {31'b0, bus_a.UNDERRUN}, 32'd0);

    // Single word then idle: 3 chunks, 7 bits left, underrun.
    reset_a();
`ifdef GEARBOX_TX_BIT_REVERSE_EN
    exp_first = 20'h7B3D5;
`else
    exp_first = 20'hABCDE;
`endif
    bus_a.DATA_IN = {20'hABCDE, 47'h0};
    bus_a.DATA_IN_VALID = 1'b1;
    @(negedge clk);
    bus_a.DATA_IN_VALID = 1'b0;
    chk("one_fill", {25'b0, bus_a.FILL_LEVEL}, 32'd67);
    chk("one_no_bypass", {31'b0, bus_a.DATA_OUT_VALID}, 32'd0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_a.DATA_OUT_VALID) begin
        nv++;
        if (nv == 1) chk("one_first_chunk", {12'b0, bus_a.DATA_OUT}, {12'b0, exp_first});
      end
    end
    chk("one_chunks", nv, 32'd3);
    chk("one_fill_end", {25'b0, bus_a.FILL_LEVEL}, 32'd7);
    chk("one_valid_end", {31'b0, bus_a.DATA_OUT_VALID}, 32'd0);
    chk("one_underrun", {31'b0, bus_a.UNDERRUN}, 32'd1);

    // Reset mid-stream at fill 54, then a fresh word.
    reset_a();
    bus_a.DATA_IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_a.DATA_IN = rand67();
      @(negedge clk);
    end
    chk("mid_fill54", {25'b0, bus_a.FILL_LEVEL}, 32'd54);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    bus_a.DATA_IN_VALID = 1'b0;
    chk("mid_rst_fill", {25'b0, bus_a.FILL_LEVEL}, 32'd0);
    chk("mid_rst_valid", {31'b0, bus_a.DATA_OUT_VALID}, 32'd0);
    chk("mid_rst_underrun", {31'b0, bus_a.UNDERRUN}, 32'd0);
    w = rand67();
    bus_a.DATA_IN = w;
    bus_a.DATA_IN_VALID = 1'b1;
    @(negedge clk);
    bus_a.DATA_IN_VALID = 1'b0;
    @(negedge clk);
    chk("mid_fresh_chunk", {12'b0, bus_a.DATA_OUT}, {12'b0, top_chunk(w)});

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus_a.DATA_IN = rand67();
      bus_a.DATA_IN_VALID = ($urandom_range(0, 2) != 0);
      rst_a = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst_a = 1'b0;

    for (int i = 0; i < 5000 && !b_done; i++) @(negedge clk);
    if (!b_done) chk("b_stream_timeout", 32'd0, 32'd1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gearbox_tx_param.md
GEARBOX_TX_PARAM -- requirements
Module: gearbox_tx_param

Interface
REQ-001 The block SHALL provide parameter IN_W, default 67, meaning input word width in bits (legal: IN_W >= OUT_W).
REQ-002 The block SHALL provide parameter OUT_W, default 20, meaning output word width in bits (legal: OUT_W >= 2).
REQ-003 Derived constants SHALL be STORE_W = IN_W+OUT_W-1 and CNT_W = clog2(STORE_W+1).
REQ-004 Port USER_CLK SHALL be an input of width 1: the single clock; all state changes on its rising edge.
REQ-005 Port SYSTEM_RESET SHALL be an input of width 1: the reset, synchronous and active-high.
REQ-006 Port DATA_IN SHALL be an input of width IN_W: the input word; DATA_IN[IN_W-1] is transmitted first.
REQ-007 Port DATA_IN_VALID SHALL be an input of width 1: DATA_IN is offered.
REQ-008 Port DATA_IN_READY SHALL be an output of width 1 (combinational): the block can take DATA_IN this cycle.
REQ-009 Port DATA_OUT SHALL be a registered output of width OUT_W: the output chunk.
REQ-010 Port DATA_OUT_VALID SHALL be a registered output of width 1: DATA_OUT carries a real chunk.
REQ-011 Port FILL_LEVEL SHALL be an output of width CNT_W: the registered count of stored bits, cnt.
REQ-012 Port UNDERRUN SHALL be a registered output of width 1: sticky underrun flag.

Function
REQ-013 Storage SHALL be a STORE_W-bit MSB-aligned shift buffer holding cnt valid bits at the top (oldest bit at STORE_W-1).
REQ-014 Drain condition SHALL be drain = (cnt >= OUT_W), evaluated on registered cnt.
REQ-015 Post-drain fill SHALL be cnt_d = cnt - (drain ? OUT_W : 0).
REQ-016 DATA_IN_READY SHALL equal (cnt_d + IN_W <= STORE_W), with no dependence on DATA_IN_VALID.
REQ-017 A word SHALL be accepted on a rising edge only when DATA_IN_VALID and DATA_IN_READY are both 1.
REQ-018 An accepted word SHALL be written to the bits immediately below the cnt_d retained bits.
REQ-019 Drain and accept in the same cycle SHALL give next cnt = cnt_d + IN_W; otherwise next cnt = cnt_d.
REQ-020 On drain, the next DATA_OUT SHALL be the top OUT_W stored bits, DATA_OUT_VALID SHALL be 1, and storage SHALL shift left by OUT_W with zero fill.
REQ-021 Without drain, the next DATA_OUT SHALL be all zeros and DATA_OUT_VALID SHALL be 0.
REQ-022 Latency SHALL be: a word accepted on edge k has its first chunk on DATA_OUT after edge k+1; no input-to-output bypass.
REQ-023 UNDERRUN SHALL set on any non-drain cycle occurring after at least one valid chunk has been emitted since reset, and SHALL stay set until reset.
REQ-024 DATA_IN SHALL be ignored whenever DATA_IN_READY = 0, with no loss or duplication of bits.
REQ-025 Bit order SHALL be preserved exactly: the output bit stream is the concatenation of accepted words, MSB first.

Reset
REQ-026 While SYSTEM_RESET = 1 at an edge, cnt, storage, DATA_OUT, DATA_OUT_VALID, UNDERRUN and the emitted-once flag SHALL clear to 0; DATA_IN SHALL be dropped.
REQ-027 Reset mid-stream SHALL discard all stored bits, and the first post-reset accepted word SHALL start at storage bit STORE_W-1.
REQ-028 Immediately after reset, DATA_IN_READY SHALL be 1.

Configuration
REQ-029 With macro GEARBOX_TX_BIT_REVERSE_EN defined, DATA_OUT[i] SHALL equal chunk[OUT_W-1-i], placing the first-transmitted bit at DATA_OUT[0] (transceiver order).
REQ-030 With GEARBOX_TX_BIT_REVERSE_EN undefined, DATA_OUT SHALL equal chunk unchanged, with the first-transmitted bit at DATA_OUT[OUT_W-1].

Verification
REQ-031 Defaults, reset then DATA_IN_VALID held 1 -> DATA_IN_READY = 1,0,0,1 in cycles 0..3; FILL_LEVEL = 0,67,47,27,74; UNDERRUN never sets.
REQ-032 Defaults, single word {20'hABCDE,47'h0} -> first DATA_OUT = 20'hABCDE without macro and 20'h7B3D5 with GEARBOX_TX_BIT_REVERSE_EN.
REQ-033 Defaults, one word then DATA_IN_VALID = 0 -> exactly 3 valid chunks, FILL_LEVEL settles at 7, then DATA_OUT_VALID = 0 and UNDERRUN = 1.
REQ-034 SYSTEM_RESET pulsed with FILL_LEVEL = 54 -> next cycle FILL_LEVEL = 0, DATA_OUT_VALID = 0, UNDERRUN = 0, and a fresh word appears intact.
REQ-035 IN_W = 66, OUT_W = 32, random stream with random valid gaps -> output bit stream equals the input concatenation; FILL_LEVEL never exceeds 97.
